// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multicycle control path:
// FSM state codes, opcode classes, opcode match values and ALU control codes.
package legv8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_BRANCH,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RTYPE,
        CLS_MOVZ,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B
    } opclass_t;

    // Opcode match values, each aligned to the top of instr[31:21]
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_EOR  = 11'h650;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [8:0]  OP_MOVZ = 9'h1A5;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;
    localparam logic [5:0]  OP_B    = 6'h05;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ORR  = 4'b0100;
    localparam logic [3:0] ALU_EOR  = 4'b1001;
    localparam logic [3:0] ALU_MOVZ = 4'b1101;
    localparam logic [3:0] ALU_CBZ  = 4'b0111;
    localparam logic [3:0] ALU_CBNZ = 4'b0001;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode decoder: maps instr[31:21] to an opcode class plus the
// ALU code, immediate select and reg2loc select that class needs.
module legv8_opcode_decode
    import legv8_pkg::*;
(
    input  logic [10:0] i_opcode,
    output logic [2:0]  o_class,
    output logic [3:0]  o_alu_control,
    output logic        o_alu_src,
    output logic        o_reg2loc,
    output logic        o_illegal
);

    opclass_t   w_class;
    logic [3:0] w_alu;
    logic       w_src;
    logic       w_r2l;

    // Full 11-bit opcodes win over the shorter MOVZ / CB / B prefixes
    always_comb begin
        w_class = CLS_ILLEGAL;
        w_alu   = 4'b0000;
        w_src   = 1'b0;
        w_r2l   = 1'b0;
        case (i_opcode)
            OP_ADD:  begin w_class = CLS_RTYPE; w_alu = ALU_ADD; end
            OP_SUB:  begin w_class = CLS_RTYPE; w_alu = ALU_SUB; end
            OP_AND:  begin w_class = CLS_RTYPE; w_alu = ALU_AND; end
            OP_ORR:  begin w_class = CLS_RTYPE; w_alu = ALU_ORR; end
            OP_EOR:  begin w_class = CLS_RTYPE; w_alu = ALU_EOR; end
            OP_LDUR: begin w_class = CLS_LDUR; w_alu = ALU_ADD; w_src = 1'b1; end
            OP_STUR: begin
                w_class = CLS_STUR;
                w_alu   = ALU_ADD;
                w_src   = 1'b1;
                w_r2l   = 1'b1;
            end
            default: begin
                if (i_opcode[10:2] == OP_MOVZ) begin
                    w_class = CLS_MOVZ;
                    w_alu   = ALU_MOVZ;
                    w_src   = 1'b1;
                end else if (i_opcode[10:3] == OP_CBZ) begin
                    w_class = CLS_CBZ;
                    w_alu   = ALU_CBZ;
                    w_r2l   = 1'b1;
                end else if (i_opcode[10:3] == OP_CBNZ) begin
                    w_class = CLS_CBNZ;
                    w_alu   = ALU_CBNZ;
                    w_r2l   = 1'b1;
                end else if (i_opcode[10:5] == OP_B) begin
                    w_class = CLS_B;
                end
            end
        endcase
    end

    assign o_class       = w_class;
    assign o_alu_control = w_alu;
    assign o_alu_src     = w_src;
    assign o_reg2loc     = w_r2l;
    assign o_illegal     = (w_class == CLS_ILLEGAL);

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 control sequencer: FSM, opcode latch and memory-wait timeout.
// Outputs decode only the state register, latched opcode, taken flag and wait count.
module legv8_multicycle_control
    import legv8_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr_rdata,
    input  logic        i_mem_ready,
    input  logic        i_alu_zero,
    output logic [3:0]  o_alu_control,
    output logic        o_alu_src,
    output logic        o_reg2loc,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_i_or_d,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic        o_illegal_op,
    output logic        o_bus_error,
    output logic        o_halted
);

    localparam int            CW    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t        r_state;
    logic [10:0]   r_opcode;
    logic          r_taken;
    logic [CW-1:0] r_wait_cnt;

    logic [2:0] w_class_bits;
    opclass_t   w_class;
    logic [3:0] w_alu;
    logic       w_src;
    logic       w_r2l;
    logic       w_illegal;
    logic       w_timeout;

    legv8_opcode_decode u_decode (
        .i_opcode      (r_opcode),
        .o_class       (w_class_bits),
        .o_alu_control (w_alu),
        .o_alu_src     (w_src),
        .o_reg2loc     (w_r2l),
        .o_illegal     (w_illegal)
    );

    assign w_class   = opclass_t'(w_class_bits);
    assign w_timeout = (WAIT_LIMIT != 0) && (r_wait_cnt == LIMIT) &&
                       ((r_state == ST_FETCH) || (r_state == ST_MEM));

    // The wait counter is cleared on every transition into FETCH or MEM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_taken    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (w_timeout) begin
                        r_state <= ST_HALT;
                    end else if (i_mem_ready) begin
                        r_opcode <= i_instr_rdata[31:21];
                        r_state  <= ST_DECODE;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + ONE;
                    end
                end
                ST_DECODE: begin
                    if (w_class == CLS_B) begin
                        r_taken <= 1'b1;
                        r_state <= ST_BRANCH;
                    end else if (w_illegal) begin
                        r_state    <= ST_FETCH;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (w_class)
                        CLS_RTYPE, CLS_MOVZ: r_state <= ST_WRITEBACK;
                        CLS_LDUR, CLS_STUR: begin
                            r_state    <= ST_MEM;
                            r_wait_cnt <= '0;
                        end
                        CLS_CBZ, CLS_CBNZ: begin
                            r_taken <= i_alu_zero;
                            r_state <= ST_BRANCH;
                        end
                        default: begin
                            r_state    <= ST_FETCH;
                            r_wait_cnt <= '0;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (w_timeout) begin
                        r_state <= ST_HALT;
                    end else if (i_mem_ready) begin
                        if (w_class == CLS_LDUR) begin
                            r_state <= ST_WRITEBACK;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_wait_cnt <= '0;
                        end
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + ONE;
                    end
                end
                ST_WRITEBACK, ST_BRANCH: begin
                    r_state    <= ST_FETCH;
                    r_wait_cnt <= '0;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The timeout cycle drops the request and raises bus_error before HALT
    always_comb begin
        o_alu_control = 4'b0000;
        o_alu_src     = 1'b0;
        o_reg2loc     = 1'b0;
        o_reg_write   = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_i_or_d      = 1'b0;
        o_pc_inc      = 1'b0;
        o_pc_load     = 1'b0;
        o_illegal_op  = 1'b0;
        o_bus_error   = 1'b0;
        o_halted      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_bus_error = w_timeout;
                o_mem_req   = !w_timeout;
            end
            ST_DECODE: begin
                o_pc_inc     = 1'b1;
                o_reg2loc    = w_r2l;
                o_illegal_op = w_illegal;
            end
            ST_EXECUTE: begin
                o_alu_control = w_alu;
                o_alu_src     = w_src;
                o_reg2loc     = w_r2l;
            end
            ST_MEM: begin
                o_alu_control = w_alu;
                o_alu_src     = w_src;
                o_reg2loc     = w_r2l;
                o_bus_error   = w_timeout;
                o_mem_req     = !w_timeout;
                o_i_or_d      = !w_timeout;
                o_mem_we      = !w_timeout && (w_class == CLS_STUR);
            end
            ST_WRITEBACK: begin
                o_alu_control = w_alu;
                o_alu_src     = w_src;
                o_reg2loc     = w_r2l;
                o_reg_write   = 1'b1;
                o_mem_to_reg  = (w_class == CLS_LDUR);
            end
            ST_BRANCH: begin
                o_reg2loc = w_r2l;
                o_pc_load = r_taken;
            end
            ST_HALT: o_halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Bench for legv8_multicycle_control: per-cycle vector table feeding a scoreboard
// queue, plus a hand-written timeout sequence.
module tb_legv8_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrRdata;
    logic        memReady;
    logic        aluZero;
    logic [3:0]  aluControl;
    logic        aluSrc, reg2loc, regWrite, memToReg, memReq, memWe, iOrD;
    logic        pcInc, pcLoad, illegalOp, busError, halted;
    logic [15:0] actual;

    always #5 clk = ~clk;

    legv8_multicycle_control #(.WAIT_LIMIT(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_instr_rdata (instrRdata),
        .i_mem_ready   (memReady),
        .i_alu_zero    (aluZero),
        .o_alu_control (aluControl),
        .o_alu_src     (aluSrc),
        .o_reg2loc     (reg2loc),
        .o_reg_write   (regWrite),
        .o_mem_to_reg  (memToReg),
        .o_mem_req     (memReq),
        .o_mem_we      (memWe),
        .o_i_or_d      (iOrD),
        .o_pc_inc      (pcInc),
        .o_pc_load     (pcLoad),
        .o_illegal_op  (illegalOp),
        .o_bus_error   (busError),
        .o_halted      (halted)
    );

    assign actual = {aluControl, aluSrc, reg2loc, regWrite, memToReg, memReq, memWe,
                     iOrD, pcInc, pcLoad, illegalOp, busError, halted};

    localparam logic [15:0] K_ADD  = 16'h2000;
    localparam logic [15:0] K_CBZ  = 16'h7000;
    localparam logic [15:0] K_CBNZ = 16'h1000;
    localparam logic [15:0] SRC    = 16'h0800;
    localparam logic [15:0] R2L    = 16'h0400;
    localparam logic [15:0] RW     = 16'h0200;
    localparam logic [15:0] M2R    = 16'h0100;
    localparam logic [15:0] REQ    = 16'h0080;
    localparam logic [15:0] WE     = 16'h0040;
    localparam logic [15:0] IORD   = 16'h0020;
    localparam logic [15:0] PCI    = 16'h0010;
    localparam logic [15:0] PCL    = 16'h0008;
    localparam logic [15:0] ILL    = 16'h0004;
    localparam logic [15:0] BERR   = 16'h0002;
    localparam logic [15:0] HLT    = 16'h0001;
    localparam logic [15:0] NONE   = 16'h0000;

    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_LDUR = 32'hF8400020;
    localparam logic [31:0] I_STUR = 32'hF8000020;
    localparam logic [31:0] I_CBZ  = 32'hB4000040;
    localparam logic [31:0] I_CBNZ = 32'hB5000040;
    localparam logic [31:0] I_B    = 32'h14000010;
    localparam logic [31:0] I_ILL  = 32'h00000000;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        zero;
        logic [31:0] instr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
        int          idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    sb_t  monEntry;
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input int idx, input logic [15:0] got,
                               input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s (row %0d): got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic addVec(input logic rst, input logic ready, input logic zero,
                          input logic [31:0] instr, input logic [15:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.ready = ready; v.zero = zero;
        v.instr = instr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One row = one clock cycle: inputs held during it, outputs expected in it
    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t s;
        @(posedge clk);
        #1;
        reset      = v.rst;
        memReady   = v.ready;
        aluZero    = v.zero;
        instrRdata = v.instr;
        s.exp  = v.exp;
        s.name = v.name;
        s.idx  = idx;
        sbq.push_back(s);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            monEntry = sbq.pop_front();
            checkOutput(monEntry.name, monEntry.idx, actual, monEntry.exp);
        end
    end

    initial begin
        int waitCycles;
        logic sawBusError;

        reset = 1'b1; memReady = 1'b0; aluZero = 1'b0; instrRdata = 32'h0;

        addVec(1'b0, 1'b1, 1'b0, I_ADD, NONE, "reset_idle");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, REQ, "add_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, PCI, "add_decode");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, K_ADD, "add_exec");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, K_ADD | RW, "add_wb");

        addVec(1'b0, 1'b1, 1'b0, I_LDUR, REQ, "ldur_fetch");
        addVec(1'b0, 1'b0, 1'b0, I_LDUR, PCI, "ldur_decode");
        addVec(1'b0, 1'b0, 1'b0, I_LDUR, K_ADD | SRC, "ldur_exec");
        for (int i = 0; i < 3; i++)
            addVec(1'b0, 1'b0, 1'b0, I_LDUR, K_ADD | SRC | REQ | IORD, "ldur_mem_wait");
        addVec(1'b0, 1'b1, 1'b0, I_LDUR, K_ADD | SRC | REQ | IORD, "ldur_mem_ready");
        addVec(1'b0, 1'b1, 1'b0, I_LDUR, K_ADD | SRC | RW | M2R, "ldur_wb");

        addVec(1'b0, 1'b1, 1'b0, I_CBZ, REQ, "cbz_t_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_CBZ, PCI | R2L, "cbz_t_decode");
        addVec(1'b0, 1'b1, 1'b1, I_CBZ, K_CBZ | R2L, "cbz_t_exec");
        addVec(1'b0, 1'b1, 1'b0, I_CBZ, R2L | PCL, "cbz_t_branch");
        addVec(1'b0, 1'b1, 1'b0, I_CBZ, REQ, "cbz_n_fetch");
        addVec(1'b0, 1'b1, 1'b1, I_CBZ, PCI | R2L, "cbz_n_decode");
        addVec(1'b0, 1'b1, 1'b0, I_CBZ, K_CBZ | R2L, "cbz_n_exec");
        addVec(1'b0, 1'b1, 1'b1, I_CBZ, R2L, "cbz_n_branch");

        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, REQ, "cbnz_t_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, PCI | R2L, "cbnz_t_decode");
        addVec(1'b0, 1'b1, 1'b1, I_CBNZ, K_CBNZ | R2L, "cbnz_t_exec");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, R2L | PCL, "cbnz_t_branch");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, REQ, "cbnz_n_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, PCI | R2L, "cbnz_n_decode");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, K_CBNZ | R2L, "cbnz_n_exec");
        addVec(1'b0, 1'b1, 1'b0, I_CBNZ, R2L, "cbnz_n_branch");

        addVec(1'b0, 1'b1, 1'b0, I_B, REQ, "b_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_B, PCI, "b_decode");
        addVec(1'b0, 1'b1, 1'b0, I_B, PCL, "b_branch");

        addVec(1'b0, 1'b1, 1'b0, I_STUR, REQ, "stur_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_STUR, PCI | R2L, "stur_decode");
        addVec(1'b0, 1'b1, 1'b0, I_STUR, K_ADD | SRC | R2L, "stur_exec");
        addVec(1'b0, 1'b1, 1'b0, I_STUR, K_ADD | SRC | R2L | REQ | WE | IORD, "stur_mem");

        addVec(1'b0, 1'b1, 1'b0, I_ILL, REQ, "ill_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_ILL, PCI | ILL, "ill_decode");

        addVec(1'b0, 1'b1, 1'b0, I_LDUR, REQ, "rst_fetch");
        addVec(1'b0, 1'b0, 1'b0, I_LDUR, PCI, "rst_decode");
        addVec(1'b0, 1'b0, 1'b0, I_LDUR, K_ADD | SRC, "rst_exec");
        addVec(1'b1, 1'b0, 1'b0, I_LDUR, K_ADD | SRC | REQ | IORD, "rst_mem");
        addVec(1'b0, 1'b0, 1'b0, I_LDUR, NONE, "rst_idle");

        for (int i = 0; i < 4; i++)
            addVec(1'b0, 1'b0, 1'b0, I_ADD, REQ, "to_wait");
        addVec(1'b0, 1'b0, 1'b0, I_ADD, BERR, "to_buserr");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, HLT, "halt_hold");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, HLT, "halt_hold");
        addVec(1'b1, 1'b1, 1'b0, I_ADD, HLT, "halt_reset");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, NONE, "halt_idle");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, REQ, "post_fetch");
        addVec(1'b0, 1'b1, 1'b0, I_ADD, PCI, "post_decode");

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Timeout from a fresh reset, measured directly with a bounded wait
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; memReady = 1'b0;
        waitCycles = 0;
        sawBusError = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busError) begin
                sawBusError = 1'b1;
                break;
            end
            if (memReq) waitCycles++;
        end
        checkOutput("hs_bus_error_seen", 0, {15'd0, sawBusError}, 16'd1);
        checkOutput("hs_wait_cycles", 0, 16'(waitCycles), 16'd4);
        @(negedge clk);
        checkOutput("hs_halted", 0, {15'd0, halted}, 16'd1);
        checkOutput("hs_req_dropped", 0, {15'd0, memReq}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
